sdram_arbiter: RTL

- Shares the single sdram_controller logical port between two requesters:
  - the SPI emulation path (high priority, latency-critical while flash CS is asserted);
  - the user_command_parser (low priority, bulk load/dump).
- Replaces ad-hoc muxing in top.
- Sequences ownership handover so an in-flight user operation is never corrupted.
- Routes read completions to the requester that issued them.
- Polices refresh starvation while SPI holds the bus.

---
 rtl/sdram_arbiter_pkg.sv | 24 ++
 rtl/sdram_arbiter_refresh_watchdog.sv | 46 ++++
 rtl/sdram_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared encodings for the SDRAM port arbiter: bus owner and arbitration state.
// Both the top and the refresh watchdog import this package.
package sdram_arbiter_pkg;

    typedef enum logic {
        OWN_USER = 1'b0,
        OWN_SPI  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_USER  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SPI   = 2'd2
    } state_e;

    localparam int DEFAULT_ADDR_BITS   = 25;
    localparam int DEFAULT_REFRESH_MAX = 750;

    // DRAIN still belongs to the user: its last operation is retiring.
    function automatic owner_e owner_of(input state_e st);
        return (st == ST_SPI) ? OWN_SPI : OWN_USER;
    endfunction

endpackage

// File: rtl/sdram_arbiter_refresh_watchdog.sv
// Counts consecutive refresh-inhibited cycles (saturating) and raises a sticky
// overrun flag once the run length reaches REFRESH_MAX.
module sdram_arbiter_refresh_watchdog
    import sdram_arbiter_pkg::*;
#(
    parameter int REFRESH_MAX = DEFAULT_REFRESH_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inhibit,
    output logic o_overrun
);

    localparam int CW = $clog2(REFRESH_MAX + 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_overrun;

    always_comb begin
        w_count_next = '0;
        if (i_inhibit) begin
            if (r_count == CW'(REFRESH_MAX)) begin
                w_count_next = r_count;
            end else begin
                w_count_next = r_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_count <= w_count_next;
            // Sticky until reset; the grant itself is never revoked here.
            if (w_count_next == CW'(REFRESH_MAX)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_overrun = r_overrun;

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the single SDRAM controller port between the SPI flash emulation
// path (priority, exclusive while locked) and the user command parser.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
    parameter int REFRESH_MAX = DEFAULT_REFRESH_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_lock,
    output logic                 spi_grant,
    input  logic [ADDR_BITS-1:0] spi_addr,
    input  logic                 spi_enable,
    input  logic                 spi_pause_cas,
    output logic                 spi_busy,
    output logic                 spi_rd_ready,
    input  logic [ADDR_BITS-1:0] user_addr,
    input  logic [7:0]           user_wr_data,
    input  logic                 user_we,
    input  logic                 user_enable,
    input  logic                 user_refresh_inhibit,
    output logic                 user_busy,
    output logic                 user_rd_ready,
    output logic [ADDR_BITS-1:0] sd_addr,
    output logic [7:0]           sd_wr_data,
    output logic                 sd_we,
    output logic                 sd_enable,
    output logic                 sd_refresh_inhibit,
    output logic                 sd_pause_cas,
    input  logic                 sd_busy,
    input  logic                 sd_rd_ready,
    output logic                 refresh_overrun
);

    state_e r_state;
    state_e w_state_next;
    logic   r_rd_pending;
    owner_e r_rd_owner;

    logic   w_own_spi;
    logic   w_own_user;
    logic   w_accept_rd;
    logic   w_rd_busy;
    logic   w_bus_quiet;

    assign w_own_spi  = (r_state == ST_SPI);
    assign w_own_user = (r_state == ST_USER);

    // Zero-latency request forwarding from the current owner. In DRAIN the
    // user's fields still drive the bus but no new request may start.
    always_comb begin
        sd_addr      = w_own_spi ? spi_addr : user_addr;
        sd_wr_data   = w_own_spi ? 8'h00 : user_wr_data;
        sd_we        = 1'b0;
        sd_enable    = 1'b0;
        sd_pause_cas = 1'b0;
        if (!reset) begin
            if (w_own_spi) begin
                sd_enable    = spi_enable;
                sd_pause_cas = spi_pause_cas;
            end else begin
                sd_we     = user_we;
                sd_enable = w_own_user & user_enable & ~spi_lock;
            end
        end
    end

    assign sd_refresh_inhibit = ~w_own_user | user_refresh_inhibit;
    assign spi_grant          = w_own_spi;
    assign spi_busy           = sd_busy | ~w_own_spi;
    assign user_busy          = sd_busy | ~w_own_user | spi_lock;

    // A read retiring this cycle no longer blocks a handover; one being
    // accepted this cycle does.
    assign w_accept_rd = sd_enable & ~sd_we & ~sd_busy;
    assign w_rd_busy   = (r_rd_pending & ~sd_rd_ready) | w_accept_rd;
    assign w_bus_quiet = ~sd_busy & ~w_rd_busy;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_USER: begin
                if (spi_lock) begin
                    w_state_next = w_bus_quiet ? ST_SPI : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!spi_lock) begin
                    w_state_next = ST_USER;
                end else if (w_bus_quiet) begin
                    w_state_next = ST_SPI;
                end
            end
            ST_SPI: begin
                if (!spi_lock && w_bus_quiet) begin
                    w_state_next = ST_USER;
                end
            end
            default: w_state_next = ST_USER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_USER;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pending <= 1'b0;
            r_rd_owner   <= OWN_USER;
        end else if (w_accept_rd) begin
            r_rd_pending <= 1'b1;
            r_rd_owner   <= owner_of(r_state);
        end else if (sd_rd_ready) begin
            r_rd_pending <= 1'b0;
        end
    end

    // Completions follow whoever issued the read, not whoever owns the bus now.
    assign spi_rd_ready  = sd_rd_ready & (r_rd_owner == OWN_SPI);
    assign user_rd_ready = sd_rd_ready & (r_rd_owner == OWN_USER);

    sdram_arbiter_refresh_watchdog #(
        .REFRESH_MAX (REFRESH_MAX)
    ) u_refresh_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_inhibit (sd_refresh_inhibit),
        .o_overrun (refresh_overrun)
    );

endmodule
